// File: rtl/hazard_scoreboard.sv
// ============================================================================
// Module   : hazard_scoreboard
// Purpose  : Shift-register scoreboard deciding stall / bypass for the D stage.
// Revision : 1.0
// ============================================================================
`default_nettype none

module hazard_scoreboard #(
    parameter int REG_AW   = 4,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1,
    parameter int FWD_EN   = 1,
    parameter int CW       = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  instr_D,
    input  logic                         valid_D,
    input  logic                         isWb_D,
    input  logic                         flush,
    output logic                         stall,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_a,
    output logic [$clog2(DEPTH+1)-1:0]   fwd_sel_b,
    output logic [CW-1:0]                stall_count
);

    localparam int SW   = $clog2(DEPTH + 1);
    localparam int CNTW = $clog2(DEPTH + 1);

    localparam logic [4:0] c_op_not  = 5'b01000;
    localparam logic [4:0] c_op_mov  = 5'b01001;
    localparam logic [4:0] c_op_cmpl = 5'b01010;
    localparam logic [4:0] c_op_nop  = 5'b01101;
    localparam logic [4:0] c_op_ld   = 5'b01110;
    localparam logic [4:0] c_op_st   = 5'b01111;
    localparam logic [4:0] c_op_beq  = 5'b10000;
    localparam logic [4:0] c_op_bgt  = 5'b10001;
    localparam logic [4:0] c_op_b    = 5'b10010;
    localparam logic [4:0] c_op_call = 5'b10011;
    localparam logic [4:0] c_op_ret  = 5'b10100;

    // Without bypassing every writer must drain past the last slot first.
    localparam logic [CNTW-1:0] c_cnt_ld  = (FWD_EN != 0) ? CNTW'(LOAD_LAT) : CNTW'(DEPTH);
    localparam logic [CNTW-1:0] c_cnt_alu = (FWD_EN != 0) ? '0 : CNTW'(DEPTH);

    typedef struct packed {
        logic          hit;
        logic          haz;
        logic [SW-1:0] sel;
    } match_t;

    logic [DEPTH-1:0]             r_v;
    logic [DEPTH-1:0][REG_AW-1:0] r_rd;
    logic [DEPTH-1:0][CNTW-1:0]   r_cnt;
    logic [CW-1:0]                r_stall_count;

    logic [4:0]        w_op;
    logic              w_imm;
    logic [REG_AW-1:0] w_rd;
    logic [REG_AW-1:0] w_rs1;
    logic [REG_AW-1:0] w_rs2;
    logic              w_use_a;
    logic              w_use_b;
    logic [REG_AW-1:0] w_src_a;
    logic [REG_AW-1:0] w_src_b;
    match_t            w_ma;
    match_t            w_mb;
    logic              w_enter;
    logic [CNTW-1:0]   w_entry_cnt;
    logic              w_unused;

    assign w_op     = instr_D[31:27];
    assign w_imm    = instr_D[26];
    assign w_rd     = instr_D[22 +: REG_AW];
    assign w_rs1    = instr_D[18 +: REG_AW];
    assign w_rs2    = instr_D[14 +: REG_AW];
    assign w_unused = ^instr_D[13:0];

    assign w_use_a = valid_D &&
                     !(w_op == c_op_not || w_op == c_op_mov || w_op == c_op_nop ||
                       w_op == c_op_beq || w_op == c_op_bgt || w_op == c_op_b   ||
                       w_op == c_op_call);
    assign w_src_a = (w_op == c_op_ret) ? REG_AW'(15) : w_rs1;
    assign w_use_b = valid_D && ((!w_imm && w_op <= c_op_cmpl) || w_op == c_op_st);
    assign w_src_b = (w_op == c_op_st) ? w_rd : w_rs2;

    // Scan oldest to youngest so the youngest matching writer overrides.
    function automatic match_t find_match(input logic use_src, input logic [REG_AW-1:0] src);
        match_t m;
        m = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (use_src && r_v[k] && r_rd[k] == src) begin
                m.hit = 1'b1;
                m.haz = (r_cnt[k] != '0);
                m.sel = SW'(k + 1);
            end
        end
        return m;
    endfunction

    always_comb begin
        w_ma = find_match(w_use_a, w_src_a);
        w_mb = find_match(w_use_b, w_src_b);
    end

    assign stall     = (w_ma.haz | w_mb.haz) & ~flush;
    assign fwd_sel_a = (FWD_EN != 0 && !stall && w_ma.hit && !w_ma.haz) ? w_ma.sel : '0;
    assign fwd_sel_b = (FWD_EN != 0 && !stall && w_mb.hit && !w_mb.haz) ? w_mb.sel : '0;

    assign w_enter     = valid_D & isWb_D & ~flush & ~stall;
    assign w_entry_cnt = (w_op == c_op_ld) ? c_cnt_ld : c_cnt_alu;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_v           <= '0;
            r_rd          <= '0;
            r_cnt         <= '0;
            r_stall_count <= '0;
        end else begin
            r_v[0]   <= w_enter;
            r_rd[0]  <= w_enter ? w_rd : '0;
            r_cnt[0] <= w_enter ? w_entry_cnt : '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k]   <= r_v[k-1];
                r_rd[k]  <= r_rd[k-1];
                r_cnt[k] <= (r_cnt[k-1] != '0) ? r_cnt[k-1] - CNTW'(1) : '0;
            end
            if (stall && r_stall_count != '1) begin
                r_stall_count <= r_stall_count + CW'(1);
            end
        end
    end

    assign stall_count = r_stall_count;

endmodule

`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_hazard_scoreboard
// Purpose  : Scoreboard bench running four configurations on shared stimulus.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_hazard_scoreboard;

    localparam int NI = 4;

    // Per-instance configuration: load latency, forwarding enable, counter max.
    int cfg_lat [NI] = '{1, 2, 1, 2};
    int cfg_fen [NI] = '{1, 1, 0, 1};
    int cfg_max [NI] = '{65535, 65535, 65535, 3};

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] instr_D = '0;
    logic        valid_D = 1'b0;
    logic        isWb_D = 1'b0;
    logic        flush = 1'b0;

    logic [NI-1:0] stall;
    logic [1:0]    fa [NI];
    logic [1:0]    fb [NI];
    logic [15:0]   sc0, sc1, sc2;
    logic [1:0]    sc3;
    logic [15:0]   sc_act [NI];

    assign sc_act[0] = sc0;
    assign sc_act[1] = sc1;
    assign sc_act[2] = sc2;
    assign sc_act[3] = {14'b0, sc3};

    always #5 clk = ~clk;

    hazard_scoreboard #(.LOAD_LAT(1), .FWD_EN(1), .CW(16)) u0 (
        .clk(clk), .reset(reset), .instr_D(instr_D), .valid_D(valid_D), .isWb_D(isWb_D),
        .flush(flush), .stall(stall[0]), .fwd_sel_a(fa[0]), .fwd_sel_b(fb[0]), .stall_count(sc0));
    hazard_scoreboard #(.LOAD_LAT(2), .FWD_EN(1), .CW(16)) u1 (
        .clk(clk), .reset(reset), .instr_D(instr_D), .valid_D(valid_D), .isWb_D(isWb_D),
        .flush(flush), .stall(stall[1]), .fwd_sel_a(fa[1]), .fwd_sel_b(fb[1]), .stall_count(sc1));
    hazard_scoreboard #(.LOAD_LAT(1), .FWD_EN(0), .CW(16)) u2 (
        .clk(clk), .reset(reset), .instr_D(instr_D), .valid_D(valid_D), .isWb_D(isWb_D),
        .flush(flush), .stall(stall[2]), .fwd_sel_a(fa[2]), .fwd_sel_b(fb[2]), .stall_count(sc2));
    hazard_scoreboard #(.LOAD_LAT(2), .FWD_EN(1), .CW(2)) u3 (
        .clk(clk), .reset(reset), .instr_D(instr_D), .valid_D(valid_D), .isWb_D(isWb_D),
        .flush(flush), .stall(stall[3]), .fwd_sel_a(fa[3]), .fwd_sel_b(fb[3]), .stall_count(sc3));

    typedef struct packed {
        logic [3:0]  st;
        logic [7:0]  fa;
        logic [7:0]  fb;
        logic [63:0] sc;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: per-cycle history of what entered E, with the absolute
    // cycle at which its value becomes bypassable.
    int now = 8;
    bit hv   [NI][8];
    int hrd  [NI][8];
    int hrdy [NI][8];
    int msc  [NI];

    task automatic chk(input int i, input string nm, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL inst%0d %s: got %0d expected %0d (t=%0t)", i, nm, act, expv, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            for (int i = 0; i < NI; i++) begin
                chk(i, "stall",       int'(stall[i]),  int'(mon_e.st[i]));
                chk(i, "fwd_sel_a",   int'(fa[i]),     int'(mon_e.fa[i*2 +: 2]));
                chk(i, "fwd_sel_b",   int'(fb[i]),     int'(mon_e.fb[i*2 +: 2]));
                chk(i, "stall_count", int'(sc_act[i]), int'(mon_e.sc[i*16 +: 16]));
            end
        end
    end

    function automatic void decode(input logic [31:0] ins, input bit v,
                                   output bit ua, output int sa, output bit ub, output int sb);
        int op;
        op = int'(ins[31:27]);
        ua = v && !(op == 8 || op == 9 || op == 13 || op == 16 || op == 17 || op == 18 || op == 19);
        sa = (op == 20) ? 15 : int'(ins[21:18]);
        ub = v && ((ins[26] == 1'b0 && op <= 10) || op == 15);
        sb = (op == 15) ? int'(ins[25:22]) : int'(ins[17:14]);
    endfunction

    function automatic void look(input int i, input bit u, input int src,
                                 output bit hit, output bit haz, output int pos);
        int idx;
        hit = 0; haz = 0; pos = 0;
        for (int k = 0; k < 3; k++) begin
            idx = (now - k) % 8;
            if (!hit && u && hv[i][idx] && hrd[i][idx] == src) begin
                hit = 1;
                pos = k;
                haz = (now < hrdy[i][idx]);
            end
        end
    endfunction

    task automatic step(input logic [31:0] ins, input bit v, input bit wb,
                        input bit fl, input bit rst, input bit chk_en);
        exp_t e;
        bit   ua, ub, ha, hb, za, zb, st;
        int   sa, sb, pa, pb, idx, lat;
        @(posedge clk);
        #1;
        instr_D = ins; valid_D = v; isWb_D = wb; flush = fl; reset = rst;
        decode(ins, v, ua, sa, ub, sb);
        e = '0;
        for (int i = 0; i < NI; i++) begin
            look(i, ua, sa, ha, za, pa);
            look(i, ub, sb, hb, zb, pb);
            st = (za || zb) && !fl;
            e.st[i] = st;
            e.fa[i*2 +: 2] = (cfg_fen[i] != 0 && !st && ha && !za) ? 2'(pa + 1) : 2'd0;
            e.fb[i*2 +: 2] = (cfg_fen[i] != 0 && !st && hb && !zb) ? 2'(pb + 1) : 2'd0;
            e.sc[i*16 +: 16] = 16'(msc[i]);
            // Advance the model to the next cycle.
            idx = (now + 1) % 8;
            if (rst) begin
                for (int j = 0; j < 8; j++) hv[i][j] = 0;
                msc[i] = 0;
            end else begin
                if (st && msc[i] < cfg_max[i]) msc[i]++;
                lat = (cfg_fen[i] != 0) ? ((ins[31:27] == 5'b01110) ? cfg_lat[i] : 0) : 3;
                hv[i][idx]   = v && wb && !fl && !st;
                hrd[i][idx]  = int'(ins[25:22]);
                hrdy[i][idx] = now + 1 + lat;
            end
        end
        if (chk_en) exp_q.push_back(e);
        now++;
    endtask

    function automatic logic [31:0] mk(input int op, input bit imm, input int rd, input int rs1, input int rs2);
        return {5'(op), imm, 4'(rd), 4'(rs1), 4'(rs2), 14'd0};
    endfunction

    logic [31:0] LD_R1, ADD_R2_R1, NOP, LD_R5, ST_R5;

    initial begin
        LD_R1     = mk(14, 1, 1, 9, 0);
        ADD_R2_R1 = mk(0, 0, 2, 1, 3);
        NOP       = mk(13, 0, 0, 0, 0);
        LD_R5     = mk(14, 1, 5, 9, 0);
        ST_R5     = mk(15, 1, 5, 6, 0);
        for (int i = 0; i < NI; i++) begin
            msc[i] = 0;
            for (int j = 0; j < 8; j++) begin
                hv[i][j] = 0; hrd[i][j] = 0; hrdy[i][j] = 0;
            end
        end

        // Reset: the first cycle's outputs depend on uninitialised state.
        step(NOP, 0, 0, 0, 1, 0);
        step(NOP, 0, 0, 0, 1, 1);
        step(NOP, 0, 0, 0, 0, 1);

        // Load-use.
        step(LD_R1, 1, 1, 0, 0, 1);
        repeat (4) step(ADD_R2_R1, 1, 1, 0, 0, 1);
        repeat (3) step(NOP, 1, 0, 0, 0, 1);

        // ALU-use on both operands, then the writer ages out.
        step(mk(0, 0, 1, 2, 3), 1, 1, 0, 0, 1);
        step(mk(1, 0, 4, 1, 1), 1, 1, 0, 0, 1);
        repeat (4) step(NOP, 1, 0, 0, 0, 1);

        // Load feeding a store's data operand.
        step(LD_R5, 1, 1, 0, 0, 1);
        repeat (4) step(ST_R5, 1, 0, 0, 0, 1);
        repeat (3) step(NOP, 1, 0, 0, 0, 1);

        // Load-use squashed by flush, then the dependent returns.
        step(LD_R1, 1, 1, 0, 0, 1);
        step(ADD_R2_R1, 1, 1, 1, 0, 1);
        repeat (3) step(ADD_R2_R1, 1, 1, 0, 0, 1);
        repeat (3) step(NOP, 1, 0, 0, 0, 1);

        // Reset during the first stall cycle.
        step(LD_R5, 1, 1, 0, 0, 1);
        step(ST_R5, 1, 0, 0, 1, 1);
        repeat (2) step(ST_R5, 1, 0, 0, 0, 1);
        repeat (3) step(NOP, 1, 0, 0, 0, 1);

        // Repeated load-use to drive the narrow counter into saturation.
        repeat (4) begin
            step(mk(14, 1, 7, 9, 0), 1, 1, 0, 0, 1);
            repeat (4) step(mk(0, 0, 8, 7, 7), 1, 1, 0, 0, 1);
        end

        // Randomised traffic over a small register set to provoke hazards.
        repeat (1500) begin
            int r;
            r = $urandom_range(0, 2);
            step(mk($urandom_range(0, 31), 1'($urandom_range(0, 1)), $urandom_range(0, 3),
                    (r == 0) ? 15 : $urandom_range(0, 3), $urandom_range(0, 3)),
                 $urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 99) == 0, 1);
        end

        step(NOP, 0, 0, 0, 0, 0);
        @(negedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
